// File: rtl/ai_i2s_pkg.sv
// Shared types and defaults for the I2S receive frame assembler.
// Channel encoding, assembler FSM states and default geometry.
package ai_i2s_pkg;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } ch_e;

   typedef enum logic {
      WAIT_L = 1'b0,
      WAIT_R = 1'b1
   } rx_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/ai_i2s_sync_fifo.sv
// First-word-fall-through synchronous FIFO with level count.
// A push into a full FIFO is accepted only when a pop frees the slot.
module ai_i2s_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level   = cnt;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: reads are gated by empty.
   always_ff @(posedge clk) begin
      if (!rst && !clr && do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ai_i2s_rx_frame_assembler.sv
// Pairs deserialized I2S words into sign-extended stereo samples
// and buffers them in a FWFT FIFO for the consumer.
module ai_i2s_rx_frame_assembler
   import ai_i2s_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [DATA_WIDTH-1:0]       word_in,
   input  logic                        word_valid,
   input  logic                        word_ch,
   input  logic [5:0]                  num_bits,
   output logic [DATA_WIDTH-1:0]       out_left,
   output logic [DATA_WIDTH-1:0]       out_right,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic                        sync_err
);

   rx_state_e             state;
   logic [DATA_WIDTH-1:0] pend_left;
   logic [DATA_WIDTH-1:0] ext;
   logic [2*DATA_WIDTH-1:0] rdata;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   int                    nb;
   logic                  sgn;

   // Out-of-range widths fall back to the full word.
   always_comb begin
      nb = int'({26'd0, num_bits});
      if (nb == 0 || nb > DATA_WIDTH) nb = DATA_WIDTH;
      sgn = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (i == nb - 1) sgn = word_in[i];
      ext = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         ext[i] = (i < nb) ? word_in[i] : sgn;
   end

   assign push = !rst && enable && word_valid &&
                 state == WAIT_R && ch_e'(word_ch) == CH_RIGHT;
   assign pop  = out_ready && !empty;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state     <= WAIT_L;
         pend_left <= '0;
         sync_err  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         if (push && full && !pop) overflow <= 1'b1;
         if (word_valid) begin
            unique case (state)
               WAIT_L: begin
                  if (ch_e'(word_ch) == CH_LEFT) begin
                     pend_left <= ext;
                     state     <= WAIT_R;
                  end else begin
                     sync_err  <= 1'b1;
                  end
               end
               WAIT_R: begin
                  if (ch_e'(word_ch) == CH_RIGHT) begin
                     state     <= WAIT_L;
                  end else begin
                     pend_left <= ext;
                     sync_err  <= 1'b1;
                  end
               end
               default: state <= WAIT_L;
            endcase
         end
      end
   end

   ai_i2s_sync_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (!enable),
      .push  (push),
      .wdata ({pend_left, ext}),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign out_left  = rdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign out_right = rdata[DATA_WIDTH-1:0];
   assign out_valid = !empty;

endmodule

// File: tb/tb_ai_i2s_rx_frame_assembler.sv
// Directed bench for the I2S frame assembler: pairing, sign
// extension, channel-order errors, FIFO full/overflow and reset.
module tb_ai_i2s_rx_frame_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] word_in;
   logic        word_valid;
   logic        word_ch;
   logic [5:0]  num_bits;
   logic [31:0] out_left;
   logic [31:0] out_right;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        sync_err;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   ai_i2s_rx_frame_assembler #(
      .DATA_WIDTH (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ch    (word_ch),
      .num_bits   (num_bits),
      .out_left   (out_left),
      .out_right  (out_right),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .sync_err   (sync_err)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tot++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Word is sampled at the posedge between the two negedges.
   task automatic send(input logic ch, input logic [31:0] w,
                       input logic [5:0] nb);
      @(negedge clk);
      word_valid = 1'b1;
      word_ch    = ch;
      word_in    = w;
      num_bits   = nb;
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic pop1();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b1;
      word_in    = '0;
      word_valid = 1'b0;
      word_ch    = 1'b0;
      num_bits   = 6'd16;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_valid", out_valid, 0);
      check("rst_left", out_left, 0);
      check("rst_right", out_right, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_serr", sync_err, 0);

      // Basic pair, consumer always ready
      out_ready = 1'b1;
      send(1'b0, 32'h0000_1234, 6'd16);
      check("b_nvalid", out_valid, 0);
      send(1'b1, 32'h0000_5678, 6'd16);
      check("b_valid", out_valid, 1);
      check("b_left", out_left, 32'h0000_1234);
      check("b_right", out_right, 32'h0000_5678);
      @(negedge clk);
      check("b_popped", out_valid, 0);
      check("b_zero_l", out_left, 0);
      out_ready = 1'b0;

      // Sign extension
      send(1'b0, 32'h0080_0000, 6'd24);
      send(1'b1, 32'h0000_8000, 6'd16);
      check("sx24_l", out_left, 32'hFF80_0000);
      check("sx16_r", out_right, 32'hFFFF_8000);
      pop1();
      send(1'b0, 32'h8000_0000, 6'd0);
      send(1'b1, 32'h1234_0007, 6'd40);
      check("sx0_l", out_left, 32'h8000_0000);
      check("sx40_r", out_right, 32'h1234_0007);
      pop1();
      send(1'b0, 32'h0000_0010, 6'd5);
      send(1'b1, 32'h0000_0001, 6'd1);
      check("sx5_l", out_left, 32'hFFFF_FFF0);
      check("sx1_r", out_right, 32'hFFFF_FFFF);
      pop1();
      check("sx_empty", fifo_level, 0);

      // Channel-order errors: R, L1, L2, R2
      send(1'b1, 32'h0000_0011, 6'd16);
      check("se_r", sync_err, 1);
      send(1'b0, 32'h0000_0001, 6'd16);
      check("se_l1", sync_err, 0);
      send(1'b0, 32'h0000_0002, 6'd16);
      check("se_l2", sync_err, 1);
      send(1'b1, 32'h0000_0003, 6'd16);
      check("se_r2", sync_err, 0);
      check("se_level", fifo_level, 1);
      check("se_left", out_left, 32'h0000_0002);
      check("se_right", out_right, 32'h0000_0003);
      pop1();
      check("se_empty", out_valid, 0);

      // Overflow: five pairs into depth four
      for (int k = 1; k <= 5; k++) begin
         send(1'b0, 32'h10 * k, 6'd16);
         send(1'b1, 32'h10 * k + 1, 6'd16);
         if (k == 4) begin
            check("of_lvl4", fifo_level, 4);
            check("of_none", overflow, 0);
         end
      end
      check("of_lvl", fifo_level, 4);
      check("of_flag", overflow, 1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("of_l%0d", k), out_left, 32'h10 * k);
         check($sformatf("of_r%0d", k), out_right, 32'h10 * k + 1);
         pop1();
      end
      check("of_drained", out_valid, 0);
      check("of_sticky", overflow, 1);
      pop1();
      check("of_no_under", fifo_level, 0);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      check("en_clr_ovf", overflow, 0);

      // Full FIFO, push and pop in the same cycle
      for (int k = 1; k <= 4; k++) begin
         send(1'b0, 32'h100 + k, 6'd16);
         send(1'b1, 32'h180 + k, 6'd16);
      end
      send(1'b0, 32'h0000_0200, 6'd16);
      @(negedge clk);
      word_valid = 1'b1;
      word_ch    = 1'b1;
      word_in    = 32'h0000_0201;
      out_ready  = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      out_ready  = 1'b0;
      check("pp_lvl", fifo_level, 4);
      check("pp_ovf", overflow, 0);
      for (int k = 2; k <= 4; k++) begin
         check($sformatf("pp_l%0d", k), out_left, 32'h100 + k);
         pop1();
      end
      check("pp_last_l", out_left, 32'h0000_0200);
      check("pp_last_r", out_right, 32'h0000_0201);
      pop1();
      check("pp_empty", fifo_level, 0);

      // Reset mid-frame with two pairs buffered
      send(1'b0, 32'h1, 6'd16);
      send(1'b1, 32'h2, 6'd16);
      send(1'b0, 32'h3, 6'd16);
      send(1'b1, 32'h4, 6'd16);
      send(1'b0, 32'h5, 6'd16);
      check("mr_lvl2", fifo_level, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_valid", out_valid, 0);
      check("mr_level", fifo_level, 0);
      check("mr_left", out_left, 0);
      check("mr_right", out_right, 0);
      send(1'b1, 32'h6, 6'd16);
      check("mr_serr", sync_err, 1);
      check("mr_nopush", out_valid, 0);

      // Enable low mid-frame also drops pending left
      send(1'b0, 32'h7, 6'd16);
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      send(1'b1, 32'h8, 6'd16);
      check("en_serr", sync_err, 1);
      check("en_nopush", fifo_level, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/ai_i2s_rx_frame_assembler.md
AI_I2S_RX_FRAME_ASSEMBLER -- requirements
Module: ai_i2s_rx_frame_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of received words and output samples.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo-pair buffer entries; power of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1: single clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port enable, input, 1: block enable; low = synchronous clear.
REQ-006 SHALL have port word_in, input, DATA_WIDTH: deserialized word, right-aligned, MSB-first order.
REQ-007 SHALL have port word_valid, input, 1: one-cycle strobe qualifying word_in.
REQ-008 SHALL have port word_ch, input, 1: channel of word_in, sampled with word_valid (0 = left, 1 = right).
REQ-009 SHALL have port num_bits, input, 6: valid bits per word.
REQ-010 SHALL have port out_left, output, DATA_WIDTH: head-of-FIFO left sample, sign-extended.
REQ-011 SHALL have port out_right, output, DATA_WIDTH: head-of-FIFO right sample, sign-extended.
REQ-012 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts head pair when out_valid and out_ready are both high.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1: pairs stored.
REQ-015 SHALL have port overflow, output, 1: sticky; a pair was dropped.
REQ-016 SHALL have port sync_err, output, 1: one-cycle pulse on channel-order violation.

Function
REQ-017 SHALL sign-extend word_in from bit N-1 to DATA_WIDTH, where N = num_bits; N = 0 or N > DATA_WIDTH is treated as DATA_WIDTH.
REQ-018 SHALL implement FSM states WAIT_L and WAIT_R; the state after reset or clear is WAIT_L.
REQ-019 In WAIT_L, word_valid with word_ch=0 SHALL latch the extended word as the pending left sample and move to WAIT_R.
REQ-020 In WAIT_L, word_valid with word_ch=1 SHALL discard the word, pulse sync_err on the next cycle, and stay in WAIT_L.
REQ-021 In WAIT_R, word_valid with word_ch=1 SHALL push {pending left, extended word} to the FIFO and move to WAIT_L.
REQ-022 In WAIT_R, word_valid with word_ch=0 SHALL replace the pending left sample, pulse sync_err, and stay in WAIT_R.
REQ-023 The FIFO SHALL be first-word-fall-through: out_left/out_right/out_valid reflect the head; a push into an empty FIFO at edge N gives out_valid=1 after edge N (latency 1 cycle from the right word_valid).
REQ-024 A pop SHALL occur when out_valid and out_ready are both high; the head advances at the same edge.
REQ-025 When full, a push with no concurrent pop SHALL drop the pair, set overflow, and leave FIFO contents unchanged.
REQ-026 When full, a simultaneous push and pop SHALL accept both; fifo_level stays FIFO_DEPTH.
REQ-027 When empty, out_ready SHALL have no effect; fifo_level never underflows.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level = writes minus reads, range 0 to FIFO_DEPTH.
REQ-029 With enable low, all state, FIFO, overflow, sync_err, and pending left sample SHALL clear at every edge; inputs are ignored.
REQ-030 overflow SHALL clear only on rst or on enable low.
REQ-031 When out_valid is 0, out_left and out_right SHALL read 0.

Reset
REQ-032 On rst=1 at a clk edge: out_left=0, out_right=0, out_valid=0, fifo_level=0, overflow=0, sync_err=0, FSM=WAIT_L, pointers=0.
REQ-033 rst asserted mid-frame SHALL discard the pending left sample and all buffered pairs; rst has priority over enable.

Structure
REQ-034 Package ai_i2s_pkg SHALL hold the channel typedef (CH_LEFT=0, CH_RIGHT=1), the FSM state enum, and the default DATA_WIDTH/FIFO_DEPTH constants.
REQ-035 The FIFO SHALL be sub-module ai_i2s_sync_fifo (parameterized width and depth, FWFT, synchronous active-high reset, full/empty/level outputs).

Verification
REQ-036 Bench SHALL cover: L=0x00001234, R=0x00005678, num_bits=16, out_ready=1 -> out_valid for 1 cycle with out_left=0x00001234, out_right=0x00005678.
REQ-037 Bench SHALL cover: num_bits=24, L word=0x00800000 -> out_left=0xFF800000; num_bits=0, word=0x80000000 -> out_left=0x80000000.
REQ-038 Bench SHALL cover: sequence R, L1, L2, R2 -> two sync_err pulses; a single pair {L2, R2} is output.
REQ-039 Bench SHALL cover: out_ready=0, 5 pairs pushed with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, pops return pairs 1 to 4 in order, pair 5 absent.
REQ-040 Bench SHALL cover: FIFO full, right-word push and pop in the same cycle -> fifo_level remains 4, overflow remains 0, new pair appears last.
REQ-041 Bench SHALL cover: rst pulse (or enable low) after a left word and with 2 pairs buffered -> all outputs 0 next cycle; the next R word gives sync_err.
